// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioning stage.
package key_cond_pkg;

  // Per-key debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // stable released
    PRESS_WAIT   = 2'd1,  // saw a press, waiting for it to stay stable
    PRESSED      = 2'd2,  // stable pressed
    RELEASE_WAIT = 2'd3   // saw a release, waiting for it to stay stable
  } key_state_t;

  // Default debounce window in milliseconds.
  localparam int DEBOUNCE_MS_DEFAULT = 10;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: a two-flop synchroniser, a debounce FSM with its own
// stability counter, and registered level/press/release/toggle outputs.
// The raw pin is active-low and the synchronised value is inverted, so
// s = 1 means "pressed". A change is accepted only after the new value has
// been seen for DEBOUNCE_CYCLES+1 consecutive synchronised samples: one to
// leave the stable state, then DEBOUNCE_CYCLES more in the wait state.
module key_debounce_ch
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       key_n_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       toggle_o,
  output logic [1:0] state_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  logic          s;
  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          toggle_q, toggle_d;

  // Two-stage synchroniser; both stages reset to the released pin value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    toggle_d  = toggle_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          press_d  = 1'b1;
          level_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counter and registered outputs; reset wins over any debounce.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign toggle_o  = toggle_q;
  assign state_o   = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Board push-button conditioner: one independent debounce channel per key.
// All outputs are registered inside the channels; nothing is combinational
// from KEY. key_state_dbg packs each channel's FSM state, key i in bits
// [2i+1:2i], for observation only.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int EXT_CLOCK_FREQ  = 50000000,
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = (EXT_CLOCK_FREQ / 1000) * DEBOUNCE_MS_DEFAULT
) (
  input  logic                  EXTCLK,
  input  logic                  RST_N,
  input  logic [NUM_KEYS-1:0]   KEY,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS-1:0]   key_toggle,
  output logic [2*NUM_KEYS-1:0] key_state_dbg
);

  // One debounce channel per key, fully independent of the others.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i    (EXTCLK),
      .rst_ni   (RST_N),
      .key_n_i  (KEY[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .toggle_o (key_toggle[i]),
      .state_o  (key_state_dbg[2*i+1:2*i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, two keys and a
// 20 ns clock. Inputs change 1 ns after a rising edge so the next edge
// samples them; outputs are read 1 ns after an edge. With a debounce of 4,
// a KEY change first sampled at edge n shows up on the outputs after
// edge n+6.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] key;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_toggle;
  logic [3:0] key_state_dbg;

  int checks;
  int failures;

  key_conditioner #(
    .EXT_CLOCK_FREQ (50000000),
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .EXTCLK       (clk),
    .RST_N        (rst_n),
    .KEY          (key),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_toggle   (key_toggle),
    .key_state_dbg(key_state_dbg)
  );

  // Clock and initial drive.
  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    key   = 2'b11;
    forever #10 clk = ~clk;
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key   = 2'b11;
    step(1);
    checks++;
    if (key_level !== 2'b00) begin
      failures++; $display("FAIL reset_level got=%b exp=00", key_level);
    end
    checks++;
    if (key_press !== 2'b00) begin
      failures++; $display("FAIL reset_press got=%b exp=00", key_press);
    end
    checks++;
    if (key_release !== 2'b00) begin
      failures++; $display("FAIL reset_release got=%b exp=00", key_release);
    end
    checks++;
    if (key_toggle !== 2'b00) begin
      failures++; $display("FAIL reset_toggle got=%b exp=00", key_toggle);
    end
    checks++;
    if (key_state_dbg !== 4'b0000) begin
      failures++; $display("FAIL reset_state got=%b exp=0000", key_state_dbg);
    end
    step(4);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
        failures++;
        $display("FAIL post_reset_idle cycle=%0d got=%b%b%b%b exp=00000000",
                 k, key_level, key_press, key_release, key_toggle);
      end
    end
  endtask

  task automatic test_clean_press();
    key = 2'b01;            // sampled first at edge n
    step(1);                // now just after edge n
    for (int k = 1; k <= 20; k++) begin
      step(1);              // just after edge n+k
      checks++;
      if (key_press[1] !== (k == 6)) begin
        failures++;
        $display("FAIL press1_pulse after_edge=n+%0d got=%b exp=%b", k, key_press[1], (k == 6));
      end
      checks++;
      if ({key_level[0], key_press[0], key_release[0], key_toggle[0]} !== 4'b0000) begin
        failures++;
        $display("FAIL key0_quiet after_edge=n+%0d got=%b%b%b%b exp=0000", k,
                 key_level[0], key_press[0], key_release[0], key_toggle[0]);
      end
    end
    checks++;
    if (key_level[1] !== 1'b1) begin
      failures++; $display("FAIL press1_level got=%b exp=1", key_level[1]);
    end
    checks++;
    if (key_toggle[1] !== 1'b1) begin
      failures++; $display("FAIL press1_toggle got=%b exp=1", key_toggle[1]);
    end
  endtask

  task automatic test_release_toggle();
    key = 2'b11;            // key 1 was held from the clean press
    step(1);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if (key_release[1] !== (k == 6)) begin
        failures++;
        $display("FAIL release1_pulse after_edge=n+%0d got=%b exp=%b", k, key_release[1], (k == 6));
      end
      checks++;
      if (key_press !== 2'b00) begin
        failures++; $display("FAIL release_no_press after_edge=n+%0d got=%b exp=00", k, key_press);
      end
    end
    checks++;
    if (key_level[1] !== 1'b0) begin
      failures++; $display("FAIL release1_level got=%b exp=0", key_level[1]);
    end
    checks++;
    if (key_toggle[1] !== 1'b1) begin
      failures++; $display("FAIL release1_toggle_kept got=%b exp=1", key_toggle[1]);
    end
    // Second clean press brings the toggle back to 0.
    key = 2'b01;
    step(11);
    checks++;
    if (key_toggle[1] !== 1'b0) begin
      failures++; $display("FAIL second_press_toggle got=%b exp=0", key_toggle[1]);
    end
    checks++;
    if (key_level[1] !== 1'b1) begin
      failures++; $display("FAIL second_press_level got=%b exp=1", key_level[1]);
    end
    key = 2'b11;
    step(12);
    checks++;
    if (key_level !== 2'b00) begin
      failures++; $display("FAIL second_release_level got=%b exp=00", key_level);
    end
  endtask

  task automatic test_bounce();
    logic pattern [0:19];
    for (int k = 0; k < 20; k++) pattern[k] = 1'b1;
    for (int k = 0; k < 3; k++) pattern[k] = 1'b0;
    for (int k = 5; k < 8; k++) pattern[k] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      key = {pattern[k], 1'b1};
      step(1);
      checks++;
      if ({key_level[1], key_press[1], key_release[1]} !== 3'b000) begin
        failures++;
        $display("FAIL bounce_rejected cycle=%0d got=%b%b%b exp=000", k,
                 key_level[1], key_press[1], key_release[1]);
      end
    end
    checks++;
    if (key_toggle !== 2'b00) begin
      failures++; $display("FAIL bounce_toggle got=%b exp=00", key_toggle);
    end
  endtask

  task automatic test_simultaneous();
    key = 2'b00;
    step(1);
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if (key_press !== ((k == 6) ? 2'b11 : 2'b00)) begin
        failures++;
        $display("FAIL simul_press after_edge=n+%0d got=%b exp=%b", k, key_press,
                 ((k == 6) ? 2'b11 : 2'b00));
      end
    end
    checks++;
    if (key_level !== 2'b11) begin
      failures++; $display("FAIL simul_level got=%b exp=11", key_level);
    end
    checks++;
    if (key_toggle !== 2'b11) begin
      failures++; $display("FAIL simul_toggle got=%b exp=11", key_toggle);
    end
    key = 2'b11;
    step(12);
    checks++;
    if (key_level !== 2'b00) begin
      failures++; $display("FAIL simul_release_level got=%b exp=00", key_level);
    end
  endtask

  task automatic test_reset_mid_debounce();
    key = 2'b01;
    step(2);
    rst_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      checks++;
      if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
        failures++;
        $display("FAIL mid_reset_outputs cycle=%0d got=%b%b%b%b exp=00000000",
                 k, key_level, key_press, key_release, key_toggle);
      end
    end
    rst_n = 1'b1;
    step(1);                // just after edge m, the first with RST_N=1
    for (int k = 1; k <= 8; k++) begin
      step(1);
      checks++;
      if (key_press[1] !== (k == 6)) begin
        failures++;
        $display("FAIL held_key_press after_edge=m+%0d got=%b exp=%b", k, key_press[1], (k == 6));
      end
    end
    checks++;
    if (key_toggle !== 2'b10) begin
      failures++; $display("FAIL held_key_toggle got=%b exp=10", key_toggle);
    end
    key = 2'b11;
    step(12);
  endtask

  // Scenario sequence and final report.
  initial begin
    checks   = 0;
    failures = 0;
    step(1);
    test_reset();
    test_clean_press();
    test_release_toggle();
    test_bounce();
    test_simultaneous();
    test_reset_mid_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input conditioning stage for the board push-buttons, upstream of the LED counter top. It synchronises the raw asynchronous active-low `KEY` pins to `EXTCLK` and debounces each key independently. Per key it produces a clean pressed level, single-cycle press and release pulses, and a press-toggled latch. The LED counter takes its enable from these outputs, so mechanical bounce never reaches its counting logic.

## Interface
Parameters:
- `EXT_CLOCK_FREQ`, default 50000000: `EXTCLK` frequency in Hz.
- `NUM_KEYS`, default 2: number of keys conditioned.
- `DEBOUNCE_CYCLES`, default `EXT_CLOCK_FREQ/100` (10 ms): stable-input cycles required to accept a change. Must be ≥ 2. Benches override it to 4.

Ports:
- `EXTCLK`, input, 1 bit: the single clock; all logic is on its rising edge.
- `RST_N`, input, 1 bit: reset, synchronous, active-low.
- `KEY`, input, `NUM_KEYS` bits: raw button pins, asynchronous, active-low (0 = pressed).
- `key_level`, output, `NUM_KEYS` bits: debounced state, active-high (1 = pressed).
- `key_press`, output, `NUM_KEYS` bits: one-cycle pulse on an accepted press.
- `key_release`, output, `NUM_KEYS` bits: one-cycle pulse on an accepted release.
- `key_toggle`, output, `NUM_KEYS` bits: flips on every accepted press.

## Operation
- Synchroniser: two flops per key. Each stage resets to "released" (raw 1). The synchronised value is inverted to active-high `s[i]`.
- Per-key FSM states: `IDLE` (stable released), `PRESS_WAIT`, `PRESSED` (stable pressed), `RELEASE_WAIT`.
- Each key has its own debounce counter, width `$clog2(DEBOUNCE_CYCLES)`.
- `IDLE`: if `s[i]`=1, go to `PRESS_WAIT` with cnt←0.
- `PRESS_WAIT`:
  - `s[i]`=0: return to `IDLE`, cnt←0, no pulse (glitch rejected).
  - `s[i]`=1 and cnt==`DEBOUNCE_CYCLES`-1: go to `PRESSED`. Set `key_press[i]`←1 for one cycle, `key_level[i]`←1, and flip `key_toggle[i]`.
  - Otherwise: cnt←cnt+1.
- `PRESSED` and `RELEASE_WAIT` mirror the above with `s[i]`=0 as the trigger.
  - Accepted release: `key_release[i]` pulses, `key_level[i]`←0.
  - `key_toggle` is unchanged by releases.
- Keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- The counter never wraps. It is cleared on every state change and never exceeds `DEBOUNCE_CYCLES`-1.

## Timing
- Reset (`RST_N`=0 at an edge): all states `IDLE`, counters 0, synchroniser flops = released.
  - All outputs read 0: `key_level`, `key_press`, `key_release`, `key_toggle`.
  - Reset takes priority over any in-flight debounce and clears `key_toggle`.
- All outputs are registered; there are no combinational paths from `KEY`.
- Latency: `KEY[i]` first sampled stable-low at edge n gives `key_press[i]`=1 and `key_level[i]`=1 after edge n+`DEBOUNCE_CYCLES`+2.
  - `key_press[i]` returns to 0 after edge n+`DEBOUNCE_CYCLES`+3.
  - Release latency is identical.
- Rejection: any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- Key held through reset release: sampled as a fresh press. A press pulse follows after `DEBOUNCE_CYCLES`+2 edges from the first edge with `RST_N`=1.
- Minimum spacing of press pulses on one key: 2·(`DEBOUNCE_CYCLES`+1) cycles.

## Structure
- Package `key_cond_pkg` holds:
  - the `key_state_t` enum (`IDLE`, `PRESS_WAIT`, `PRESSED`, `RELEASE_WAIT`);
  - `DEBOUNCE_MS_DEFAULT` = 10.
- Sub-module `key_debounce_ch` contains the per-key logic: synchroniser, FSM, counter, and the four outputs.
- `key_conditioner` instantiates `key_debounce_ch` `NUM_KEYS` times in a generate loop, with parameters passed through.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `NUM_KEYS`=2 and a 20 ns clock.
- Reset: `RST_N`=0 for 5 cycles with `KEY`=2'b11. Required: all outputs 2'b00 after the first reset edge, and held at 0 for 10 cycles after release.
- Clean press: `KEY[1]` goes to 0 at edge n and is held for 20 cycles. Required:
  - `key_press[1]` high only in the cycle after edge n+6;
  - `key_level[1]`=1 and `key_toggle[1]`=1;
  - all `KEY[0]` outputs stay 0.
- Bounce: `KEY[1]` pattern low 3 cycles, high 2, low 3, then high. Required: no pulse, `key_level[1]` stays 0.
- Release and toggle: after a clean press, set `KEY[1]`=1. Required:
  - `key_release[1]` pulses 6 edges later and `key_level[1]`=0, while `key_toggle[1]` stays 1;
  - a second clean press returns `key_toggle[1]` to 0.
- Simultaneous: `KEY`=2'b00 on the same edge. Required: `key_press`=2'b11 in the same cycle, then 2'b00.
- Reset mid-debounce: press `KEY[1]` and assert `RST_N`=0 after 2 cycles, keeping `KEY[1]` held. Required:
  - all outputs 0 during reset, with the toggle cleared;
  - after release, `key_press[1]` pulses 6 edges after the first edge with `RST_N`=1.
